// File: rtl/seg_regs_pkg.sv
// Shared register map, response codes and address decode helper for the
// 7-segment AXI4-Lite register block.
package seg_regs_pkg;

  localparam logic [3:0] OFFS_DATA    = 4'h0;
  localparam logic [3:0] OFFS_WCOUNT  = 4'h4;
  localparam logic [3:0] OFFS_SCRATCH = 4'h8;
  localparam logic [3:0] OFFS_ID      = 4'hC;

  localparam logic [31:0] ID_VALUE = 32'h5345_4731;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REG_DATA    = OFFS_DATA[3:2],
    REG_WCOUNT  = OFFS_WCOUNT[3:2],
    REG_SCRATCH = OFFS_SCRATCH[3:2],
    REG_ID      = OFFS_ID[3:2]
  } reg_sel_e;

  // Word select only; the byte lane bits [1:0] never affect the register hit.
  function automatic reg_sel_e decode_sel(input logic [3:0] addr_lo);
    logic [1:0] lane;
    lane = addr_lo[1:0];
    decode_sel = reg_sel_e'(addr_lo[3:2] | (lane & 2'b00));
  endfunction

endpackage

// File: rtl/axi_lite_seg_regs_if.sv
// AXI4-Lite signal bundle for the segment register block, with bus-side
// master and slave views.
interface axi_lite_seg_regs_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_skid.sv
// One-deep holding register for an AXI4-Lite request channel; accepts a beat
// when empty and enabled, and releases it when the consumer pops.
module axi_lite_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             enable,
  input  logic             pop,
  output logic             held,
  output logic [WIDTH-1:0] data
);

  logic             held_reg;
  logic [WIDTH-1:0] data_reg;

  assign push_ready = enable && !held_reg;
  assign held       = held_reg;
  assign data       = data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_reg <= 1'b0;
      data_reg <= '0;
    end else if (pop) begin
      held_reg <= 1'b0;
    end else if (push_valid && push_ready) begin
      held_reg <= 1'b1;
      data_reg <= push_data;
    end
  end

endmodule

// File: rtl/axi_lite_seg_regs.sv
// AXI4-Lite slave holding the 16-bit 7-segment display word, a write counter,
// a scratch register and a fixed ID.
module axi_lite_seg_regs
  import seg_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [15:0] DATA_RESET = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [15:0]           seg_data
);

  logic                  accept_enable;
  logic                  aw_held;
  logic                  w_held;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [35:0]           w_payload;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic [31:0]           wmask;
  logic                  aw_unmapped;
  logic                  ar_unmapped;
  reg_sel_e              aw_sel;
  reg_sel_e              ar_sel;

  logic [15:0] data_reg, data_next;
  logic [15:0] wcount_reg, wcount_next;
  logic [31:0] scratch_reg, scratch_next;
  logic        bvalid_reg;
  logic [1:0]  bresp_reg, bresp_next;
  logic        rvalid_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic [1:0]  rresp_reg, rresp_next;

  // A pending response blocks both request channels: one write in flight.
  assign accept_enable = !reset && !bvalid_reg;
  assign commit        = aw_held && w_held && !bvalid_reg;

  axi_lite_skid #(.WIDTH(ADDR_WIDTH)) u_aw_skid (
    .clk        (clk),
    .reset      (reset),
    .push_valid (s_axi_awvalid),
    .push_ready (s_axi_awready),
    .push_data  (s_axi_awaddr),
    .enable     (accept_enable),
    .pop        (commit),
    .held       (aw_held),
    .data       (aw_addr)
  );

  axi_lite_skid #(.WIDTH(36)) u_w_skid (
    .clk        (clk),
    .reset      (reset),
    .push_valid (s_axi_wvalid),
    .push_ready (s_axi_wready),
    .push_data  ({s_axi_wstrb, s_axi_wdata}),
    .enable     (accept_enable),
    .pop        (commit),
    .held       (w_held),
    .data       (w_payload)
  );

  assign wstrb  = w_payload[35:32];
  assign wdata  = w_payload[31:0];
  assign aw_sel = decode_sel(aw_addr[3:0]);
  assign ar_sel = decode_sel(s_axi_araddr[3:0]);

  generate
    if (ADDR_WIDTH > 4) begin : g_wide_addr
      assign aw_unmapped = |aw_addr[ADDR_WIDTH-1:4];
      assign ar_unmapped = |s_axi_araddr[ADDR_WIDTH-1:4];
    end else begin : g_narrow_addr
      assign aw_unmapped = 1'b0;
      assign ar_unmapped = 1'b0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[8*gi +: 8] = {8{wstrb[gi]}};
    end
  endgenerate

  // An all-zero strobe is a no-op with OKAY, even on an unmapped address.
  always_comb begin
    data_next    = data_reg;
    wcount_next  = wcount_reg;
    scratch_next = scratch_reg;
    bresp_next   = RESP_OKAY;
    if (wstrb != 4'h0) begin
      if (aw_unmapped) begin
        bresp_next = RESP_SLVERR;
      end else begin
        case (aw_sel)
          REG_DATA: begin
            if (|wstrb[1:0]) begin
              data_next   = (data_reg & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
              wcount_next = wcount_reg + 16'd1;
            end
          end
          REG_SCRATCH: scratch_next = (scratch_reg & ~wmask) | (wdata & wmask);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_next = 32'h0;
    rresp_next = RESP_OKAY;
    if (ar_unmapped) begin
      rresp_next = RESP_SLVERR;
    end else begin
      case (ar_sel)
        REG_DATA:    rdata_next = {16'h0, data_reg};
        REG_WCOUNT:  rdata_next = {16'h0, wcount_reg};
        REG_SCRATCH: rdata_next = scratch_reg;
        default:     rdata_next = ID_VALUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg    <= DATA_RESET;
      wcount_reg  <= 16'h0;
      scratch_reg <= 32'h0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else if (commit) begin
      data_reg    <= data_next;
      wcount_reg  <= wcount_next;
      scratch_reg <= scratch_next;
      bvalid_reg  <= 1'b1;
      bresp_reg   <= bresp_next;
    end else if (bvalid_reg && s_axi_bready) begin
      bvalid_reg <= 1'b0;
    end
  end

  // Read data samples the registers before any same-edge write commit lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= 32'h0;
      rresp_reg  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rdata_next;
      rresp_reg  <= rresp_next;
    end else if (rvalid_reg && s_axi_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = bresp_reg;
  assign s_axi_arready = !reset && !rvalid_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = rresp_reg;
  assign seg_data      = data_reg;

endmodule

// File: tb/tb_axi_lite_seg_regs.sv
// Randomized self-checking bench for axi_lite_seg_regs against a byte-level
// register model of the memory map.
module tb_axi_lite_seg_regs;

  localparam int          AW   = 5;
  localparam logic [15:0] DRST = 16'hA5C3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] seg_data;

  axi_lite_seg_regs_if #(.ADDR_WIDTH(AW)) bus ();

  axi_lite_seg_regs #(.ADDR_WIDTH(AW), .DATA_RESET(DRST)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_awaddr  (bus.awaddr),
    .s_axi_awvalid (bus.awvalid),
    .s_axi_awready (bus.awready),
    .s_axi_wdata   (bus.wdata),
    .s_axi_wstrb   (bus.wstrb),
    .s_axi_wvalid  (bus.wvalid),
    .s_axi_wready  (bus.wready),
    .s_axi_bresp   (bus.bresp),
    .s_axi_bvalid  (bus.bvalid),
    .s_axi_bready  (bus.bready),
    .s_axi_araddr  (bus.araddr),
    .s_axi_arvalid (bus.arvalid),
    .s_axi_arready (bus.arready),
    .s_axi_rdata   (bus.rdata),
    .s_axi_rresp   (bus.rresp),
    .s_axi_rvalid  (bus.rvalid),
    .s_axi_rready  (bus.rready),
    .seg_data      (seg_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_data;
  logic [15:0] m_wcount;
  logic [31:0] m_scratch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_data    = DRST;
    m_wcount  = 16'h0;
    m_scratch = 32'h0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    resp = 2'b00;
    if (s == 4'h0) return;
    if (a[AW-1:4] != '0) begin
      resp = 2'b10;
      return;
    end
    if (a[3:2] == 2'd0 && s[1:0] != 2'b00) begin
      for (int i = 0; i < 2; i++) if (s[i]) m_data[8*i +: 8] = d[8*i +: 8];
      m_wcount = m_wcount + 16'd1;
    end else if (a[3:2] == 2'd2) begin
      for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    d    = 32'h0;
    if (a[AW-1:4] != '0) resp = 2'b10;
    else begin
      case (a[3:2])
        2'd0:    d = {16'h0, m_data};
        2'd1:    d = {16'h0, m_wcount};
        2'd2:    d = m_scratch;
        default: d = 32'h5345_4731;
      endcase
    end
  endtask

  // Issues AW/W (W leading AW by w_lead cycles); returns at the negedge where B is due.
  task automatic write_issue(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    @(posedge clk); #1;
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.wvalid  = 1'b1;
    bus.awvalid = (w_lead == 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
      cyc++;
      if (!aw_done && cyc >= w_lead) bus.awvalid = 1'b1;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check_eq("aw_w_accept", {30'd0, aw_done, w_done}, 32'd3);
    @(negedge clk);
    check_eq("b_early", 32'(bus.bvalid), 32'd0);
    @(negedge clk);
    check_eq("b_latency", 32'(bus.bvalid), 32'd1);
  endtask

  task automatic b_accept(output logic [1:0] resp);
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic read_issue(input logic [AW-1:0] a);
    int cyc;
    bit done, hs;
    @(posedge clk); #1;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      hs = bus.arready;
      @(posedge clk); #1;
      if (hs) done = 1'b1;
      cyc++;
    end
    bus.arvalid = 1'b0;
    check_eq("ar_accept", 32'(done), 32'd1);
    @(negedge clk);
    check_eq("r_latency", 32'(bus.rvalid), 32'd1);
  endtask

  task automatic r_accept(output logic [31:0] d, output logic [1:0] resp);
    d    = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead);
    logic [1:0] got_resp, exp_resp;
    write_issue(a, d, s, w_lead);
    model_write(a, d, s, exp_resp);
    check_eq("seg_at_b", 32'(seg_data), {16'h0, m_data});
    b_accept(got_resp);
    check_eq("bresp", 32'(got_resp), 32'(exp_resp));
    $display("WR addr=0x%02h data=0x%08h strb=%b bresp=%b", a, d, s, got_resp);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic [31:0] exp_d;
    logic [1:0]  exp_resp;
    read_issue(a);
    r_accept(d, resp);
    model_read(a, exp_d, exp_resp);
    check_eq("rdata", d, exp_d);
    check_eq("rresp", 32'(resp), 32'(exp_resp));
    $display("RD addr=0x%02h data=0x%08h rresp=%b", a, d, resp);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  b0, r0;
    logic [31:0] rd0;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int nb, cyc;

    reset       = 1'b1;
    bus.awaddr  = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", 32'(bus.awready), 32'd0);
    check_eq("rst_wready",  32'(bus.wready),  32'd0);
    check_eq("rst_arready", 32'(bus.arready), 32'd0);
    check_eq("rst_valids",  {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    check_eq("rst_seg",     32'(seg_data), 32'(DRST));
    check_eq("rst_rdata",   bus.rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);

    for (int i = 0; i < 4; i++) do_read(AW'(4 * i), rd, rr);

    // First DATA write: display word and counter.
    do_write(AW'(0), 32'h0000_BEEF, 4'hF, 0);
    @(negedge clk);
    check_eq("seg_beef", 32'(seg_data), 32'h0000_BEEF);
    do_read(AW'(4), rd, rr);
    check_eq("wcount_one", rd, 32'd1);

    // W leads AW by two cycles; single-byte strobe into SCRATCH.
    do_write(AW'(8), 32'h1234_5678, 4'b0100, 2);
    do_read(AW'(8), rd, rr);
    check_eq("scratch_lane2", rd, 32'h0034_0000);

    // Unmapped, read-only and empty-strobe writes.
    do_read(AW'(16), rd, rr);
    check_eq("unmapped_rresp", 32'(rr), 32'd2);
    check_eq("unmapped_rdata", rd, 32'd0);
    do_write(AW'(16), 32'hFFFF_FFFF, 4'hF, 0);
    do_write(AW'(12), 32'hDEAD_0000, 4'hF, 1);
    do_write(AW'(4), 32'h0000_7777, 4'h3, 0);
    do_write(AW'(1), 32'h0000_1111, 4'h0, 0);
    do_write(AW'(2), 32'h0000_2222, 4'b1100, 0);
    for (int i = 0; i < 4; i++) do_read(AW'(4 * i + 3), rd, rr);

    // Back-pressure on both response channels.
    write_issue(AW'(0), 32'h0000_5A5A, 4'h1, 0);
    model_write(AW'(0), 32'h0000_5A5A, 4'h1, b0);
    read_issue(AW'(12));
    b0  = bus.bresp;
    r0  = bus.rresp;
    rd0 = bus.rdata;
    check_eq("stall_bresp0", 32'(b0), 32'd0);
    check_eq("stall_rdata0", rd0, 32'h5345_4731);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd3);
      check_eq("stall_bresp", 32'(bus.bresp), 32'(b0));
      check_eq("stall_rdata", bus.rdata, rd0);
      check_eq("stall_rresp", 32'(bus.rresp), 32'(r0));
      check_eq("stall_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
    end
    check_eq("stall_seg", 32'(seg_data), {16'h0, m_data});
    b_accept(rr);
    r_accept(rd, rr);

    // Random mix of reads and writes over the whole map plus unmapped space.
    for (int n = 0; n < 150; n++) begin
      a = AW'(4 * $urandom_range(0, 5) + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
        do_write(a, d, s, int'($urandom_range(0, 2)));
      end else begin
        do_read(a, rd, rr);
      end
    end

    // Reset while a write response and a read response are pending.
    write_issue(AW'(0), 32'h0000_1234, 4'h3, 0);
    read_issue(AW'(8));
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    check_eq("midrst_seg", 32'(seg_data), 32'(DRST));
    check_eq("midrst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("postrst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
    do_read(AW'(8), rd, rr);

    // 65536 back-to-back DATA writes wrap the counter to zero.
    bus.awaddr  = AW'(0);
    bus.wdata   = 32'h0000_C0DE;
    bus.wstrb   = 4'h3;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    nb  = 0;
    cyc = 0;
    while (nb < 65536 && cyc < 300000) begin
      @(negedge clk);
      if (bus.bvalid) nb++;
      @(posedge clk); #1;
      cyc++;
      if (nb == 65536) begin
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
      end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    check_eq("bulk_count", 32'(nb), 32'd65536);
    for (int i = 0; i < nb; i++) model_write(AW'(0), 32'h0000_C0DE, 4'h3, rr);
    $display("BULK writes=%0d cycles=%0d", nb, cyc);
    do_read(AW'(4), rd, rr);
    check_eq("wcount_wrap", rd, 32'd0);
    do_read(AW'(0), rd, rr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_seg_regs.md
AXI_LITE_SEG_REGS -- requirements
Module: axi_lite_seg_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, byte-address width of the AXI4-Lite port.
REQ-002 SHALL have parameter DATA_RESET, default 16'h0000, reset value of the DATA register and seg_data.
REQ-003 SHALL have port clk, input, 1, the single clock; every flop is rising-edge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports s_axi_awaddr (input, ADDR_WIDTH), s_axi_awvalid (input, 1) and s_axi_awready (output, 1), the write-address channel.
REQ-006 SHALL have ports s_axi_wdata (input, 32), s_axi_wstrb (input, 4), s_axi_wvalid (input, 1) and s_axi_wready (output, 1), the write-data channel.
REQ-007 SHALL have ports s_axi_bresp (output, 2), s_axi_bvalid (output, 1) and s_axi_bready (input, 1), the write-response channel.
REQ-008 SHALL have ports s_axi_araddr (input, ADDR_WIDTH), s_axi_arvalid (input, 1) and s_axi_arready (output, 1), the read-address channel.
REQ-009 SHALL have ports s_axi_rdata (output, 32), s_axi_rresp (output, 2), s_axi_rvalid (output, 1) and s_axi_rready (input, 1), the read-data channel.
REQ-010 SHALL have port seg_data, output, 16, the four hex digits driven straight from a flop to the downstream 7-segment multiplexer.

Function
REQ-011 Register map SHALL be decoded on addr[3:2], with addr[1:0] ignored: 0x0 DATA (RW; bits [15:0] drive seg_data; bits [31:16] read 0), 0x4 WCOUNT (RO; 16-bit count of accepted DATA writes; bits [31:16] read 0), 0x8 SCRATCH (RW, 32-bit), 0xC ID (RO, 32'h5345_4731).
REQ-012 For ADDR_WIDTH>4, any set bit above bit 3 SHALL mark the address as unmapped.
REQ-013 AW and W SHALL be accepted independently, each with a one-deep holding register; awready is high while no address is held and bvalid is low, and wready is high while no data is held and bvalid is low.
REQ-014 The register update SHALL happen in the cycle after both the address and the data are held, together with the assertion of bvalid; bvalid SHALL stay high until the cycle bready is sampled high.
REQ-015 Only one write SHALL be outstanding; no AW or W is accepted while bvalid is high.
REQ-016 WSTRB SHALL qualify writes bytewise; DATA honours strobes 0-1 only.
REQ-017 A write with all strobes zero SHALL return OKAY and change nothing, including WCOUNT.
REQ-018 WCOUNT SHALL increment by 1, wrapping 16'hFFFF to 16'h0000, on each DATA write that has at least one of strobes 0-1 set.
REQ-019 Writes to WCOUNT or ID SHALL be ignored with bresp OKAY; writes to unmapped addresses SHALL be ignored with bresp SLVERR (2'b10).
REQ-020 arready SHALL be high while rvalid is low. On an AR handshake, rdata/rresp SHALL be registered and rvalid asserted on the next cycle, then held stable until rready is sampled high.
REQ-021 rresp SHALL be SLVERR with rdata 0 for unmapped addresses, OKAY otherwise.
REQ-022 Reads and writes SHALL proceed concurrently. A read that samples in the same cycle as a write update SHALL return the pre-write value.
REQ-023 seg_data SHALL change only in the cycle the DATA update commits; it SHALL have no combinational path from any AXI input.

Reset
REQ-024 While reset is high, all ready and valid outputs SHALL be 0; after the cycle reset falls they follow REQ-013 and REQ-020.
REQ-025 Reset SHALL set seg_data=DATA_RESET, WCOUNT=0, SCRATCH=0, bresp=0, rresp=0 and rdata=0, and SHALL clear the holding registers.
REQ-026 Reset asserted mid-transaction SHALL drop any pending write or read without a response.

Structure
REQ-027 Register offsets, the ID constant and the OKAY/SLVERR encodings SHALL live in a shared package, seg_regs_pkg.
REQ-028 The module SHALL be flat; an optional sub-module axi_lite_skid for the AW/W holding registers is permitted.

Verification
REQ-029 The bench SHALL write 32'h0000_BEEF with strobe 4'hF to 0x0 and require bresp OKAY, seg_data 16'hBEEF one cycle after the B assertion, and a read of 0x4 returning 1.
REQ-030 The bench SHALL send W two cycles before AW, then write 0x8 with 32'h1234_5678 and strobe 4'b0100, starting from SCRATCH 0, and require a read of 0x8 returning 32'h0034_0000.
REQ-031 The bench SHALL read 0x10 (ADDR_WIDTH=5) and require rresp 2'b10 and rdata 0; writing 0x10 SHALL return bresp 2'b10 with no register change.
REQ-032 The bench SHALL hold bready and rready low for 5 cycles and require bvalid/rvalid and their payload stable, with awready/wready/arready low throughout.
REQ-033 The bench SHALL perform 65536 DATA writes and require WCOUNT to read 0.
REQ-034 The bench SHALL assert reset while bvalid is high and require bvalid 0 and seg_data DATA_RESET on the next cycle.
